// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file, two async read ports, one sync write port, zero-clear sweep after reset
// Ports: clk, rst (async, active-high); RegWrite/Addr3/WD3 write port; Addr1/RD1 and Addr2/RD2 combinational
//        read ports; busy high while the post-reset clear sweep runs (reads return 0, writes ignored).
// Optional: define REG_FILE_BYPASS_EN to forward WD3 to a read port addressing the register being written.
module reg_file_param #(
    parameter int DATA_W = 32,
    parameter int NREGS = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [ADDR_W-1:0] Addr2,
    input  logic [ADDR_W-1:0] Addr3,
    input  logic [DATA_W-1:0] WD3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              busy
);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] regs [NREGS];
    logic wr_ok;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            clr_ptr <= (state == CLEAR) ? clr_ptr + ADDR_W'(1) : clr_ptr;
        end
    end
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_ptr == ADDR_W'(NREGS - 1))
            state_nxt = IDLE;
    end
    always_comb begin
        busy = (state == CLEAR);
        wr_ok = !busy && RegWrite && Addr3 != '0;
    end
    // While rst is held clr_ptr sits at 0, so any edge then only rewrites 0 into
    // register 0, which always reads as zero anyway.
    always_ff @(posedge clk) begin
        if (busy)
            regs[clr_ptr] <= '0;
        else if (wr_ok)
            regs[Addr3] <= WD3;
    end
`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        RD1 = (busy || Addr1 == '0) ? '0 : (wr_ok && Addr3 == Addr1) ? WD3 : regs[Addr1];
        RD2 = (busy || Addr2 == '0) ? '0 : (wr_ok && Addr3 == Addr2) ? WD3 : regs[Addr2];
    end
`else
    always_comb begin
        RD1 = (busy || Addr1 == '0) ? '0 : regs[Addr1];
        RD2 = (busy || Addr2 == '0) ? '0 : regs[Addr2];
    end
`endif
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: scoreboard bench for reg_file_param (default 32x32 and a 64-bit x16 variant)
module tb_reg_file_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, we_a = 1'b0, busy_a;
    logic [4:0] a1_a = '0, a2_a = '0, a3_a = '0;
    logic [31:0] wd_a = '0, rd1_a, rd2_a;
    logic rst_b = 1'b1, we_b = 1'b0, busy_b;
    logic [3:0] a1_b = '0, a2_b = '0, a3_b = '0;
    logic [63:0] wd_b = '0, rd1_b, rd2_b;

    reg_file_param dut_a (
        .clk(clk), .rst(rst_a), .RegWrite(we_a), .Addr1(a1_a), .Addr2(a2_a), .Addr3(a3_a),
        .WD3(wd_a), .RD1(rd1_a), .RD2(rd2_a), .busy(busy_a)
    );
    reg_file_param #(.DATA_W(64), .NREGS(16)) dut_b (
        .clk(clk), .rst(rst_b), .RegWrite(we_b), .Addr1(a1_b), .Addr2(a2_b), .Addr3(a3_b),
        .WD3(wd_b), .RD1(rd1_b), .RD2(rd2_b), .busy(busy_b)
    );

    // Reference model: a plain array per DUT plus the number of clean edges the
    // sweep still needs. The whole array is zeroed the moment reset is seen,
    // which is indistinguishable from the sweep because reads are 0 while busy.
    logic [63:0] mem [2][32];
    int left [2] = '{0, 0};
    int nregs [2] = '{32, 16};

    always @(posedge clk) begin
        if (rst_a) begin
            left[0] = nregs[0];
            for (int i = 0; i < 32; i++) mem[0][i] = '0;
        end else if (left[0] > 0) left[0]--;
        else if (we_a && a3_a != 0) mem[0][a3_a] = {32'b0, wd_a};
        if (rst_b) begin
            left[1] = nregs[1];
            for (int i = 0; i < 32; i++) mem[1][i] = '0;
        end else if (left[1] > 0) left[1]--;
        else if (we_b && a3_b != 0) mem[1][a3_b] = wd_b;
    end

    typedef struct {
        int d;
        string nm;
        logic b;
        logic [63:0] r1;
        logic [63:0] r2;
    } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0;

    function automatic logic [63:0] rd_model(input int d, input logic b, input logic w,
                                             input int a, input int a3, input logic [63:0] wd);
        if (b || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (w && a3 != 0 && a3 == a) return wd;
`endif
        return mem[d][a];
    endfunction

    task automatic drive(input int d, input logic r, input logic w, input int x1, input int x2,
                         input int x3, input logic [63:0] wd);
        if (d == 0) begin
            rst_a = r; we_a = w; a1_a = 5'(x1); a2_a = 5'(x2); a3_a = 5'(x3); wd_a = wd[31:0];
        end else begin
            rst_b = r; we_b = w; a1_b = 4'(x1); a2_b = 4'(x2); a3_b = 4'(x3); wd_b = wd;
        end
    endtask

    task automatic expect_now(input int d, input string nm);
        exp_t e;
        logic r, w;
        int x1, x2, x3;
        logic [63:0] wd;
        r = d ? rst_b : rst_a;
        w = d ? we_b : we_a;
        x1 = d ? int'(a1_b) : int'(a1_a);
        x2 = d ? int'(a2_b) : int'(a2_a);
        x3 = d ? int'(a3_b) : int'(a3_a);
        wd = d ? wd_b : {32'b0, wd_a};
        e.d = d;
        e.nm = nm;
        e.b = r || left[d] > 0;
        e.r1 = rd_model(d, e.b, w, x1, x3, wd);
        e.r2 = rd_model(d, e.b, w, x2, x3, wd);
        q.push_back(e);
    endtask

    // Inputs change 2 time units after each rising edge, so reset edges are
    // asynchronous to clk; the monitor samples on the falling edge.
    task automatic step(input int d, input string nm, input logic r, input logic w, input int x1,
                        input int x2, input int x3, input logic [63:0] wd);
        @(posedge clk);
        #2;
        drive(d, r, w, x1, x2, x3, wd);
        expect_now(d, nm);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.nm, ".busy"}, 64'(e.d ? busy_b : busy_a), 64'(e.b));
            check({e.nm, ".rd1"}, e.d ? rd1_b : {32'b0, rd1_a}, e.r1);
            check({e.nm, ".rd2"}, e.d ? rd2_b : {32'b0, rd2_a}, e.r2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] v;
        for (int i = 0; i < 3; i++) step(0, "reset", 1, 0, 5, 3, 5, 64'hDEAD_BEEF);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 34; i++) step(0, "sweep", 0, 1, 5, i % 32, 5, 64'hDEAD_BEEF);
        step(0, "post_sweep_rd5", 0, 0, 5, 5, 0, 0);
        step(0, "wr7", 0, 1, 0, 0, 7, 64'h0000_1234);
        step(0, "rd7", 0, 0, 7, 7, 0, 0);
        step(0, "wr0", 0, 1, 0, 0, 0, 64'hFFFF_FFFF);
        step(0, "rd0", 0, 0, 0, 0, 0, 0);
        step(0, "wr9_1", 0, 1, 0, 0, 9, 64'h1);
        step(0, "wr9_2_rd", 0, 1, 9, 9, 9, 64'h2);
        step(0, "rd9_after", 0, 0, 9, 9, 0, 0);
        for (int i = 0; i < 200; i++) begin
            int x3;
            x3 = $urandom_range(0, 31);
            step(0, "rand_a", 0, 1'($urandom), ($urandom_range(0, 3) == 0) ? x3 : $urandom_range(0, 31),
                 $urandom_range(0, 31), x3, 64'($urandom));
        end
        step(0, "rst2", 1, 0, 1, 2, 0, 0);
        for (int i = 0; i < 10; i++) step(0, "sweep2", 0, 1, 7, 9, 7, 64'h55);
        step(0, "mid_pulse", 1, 1, 7, 9, 7, 64'h55);
        for (int i = 0; i < 34; i++) step(0, "sweep3", 0, 1, 7, 9, 7, 64'h66);
        for (int i = 0; i < 20; i++)
            step(0, "rand_a2", 0, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), 64'($urandom));
        step(1, "b_reset", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) step(1, "b_sweep", 0, 1, 15, i % 16, 15, 64'h0123_4567_89AB_CDEF);
        step(1, "b_wr15", 0, 1, 0, 0, 15, 64'h0123_4567_89AB_CDEF);
        step(1, "b_rd15", 0, 0, 15, 15, 0, 0);
        for (int i = 0; i < 100; i++) begin
            v = {$urandom, $urandom};
            step(1, "rand_b", 0, 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), v);
        end
        @(posedge clk);
        @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the core's 32x32 integer register file.
- Provides configurable data width and register count, with two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- After reset, a clear sequencer zeroes the whole array one entry per cycle and reports `busy` while it runs.
- Sits in the decode stage and feeds the ALU operand muxes. Writeback drives the write port.

Parameters:
- DATA_W, 32, width of each register and of the WD3/RD1/RD2 buses.
- NREGS, 32, number of architectural registers; must be a power of two and at least 2.
- ADDR_W, $clog2(NREGS), register address width; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- RegWrite  input  1  write enable for port 3.
- Addr1  input  ADDR_W  read address, port 1.
- Addr2  input  ADDR_W  read address, port 2.
- Addr3  input  ADDR_W  write address, port 3.
- WD3  input  DATA_W  write data, port 3.
- RD1  output  DATA_W  read data, port 1; combinational.
- RD2  output  DATA_W  read data, port 2; combinational.
- busy  output  1  high while the clear sequencer runs; writes are ignored and reads return 0.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- State machine has two states, CLEAR and IDLE.
- rst asserted (any time, asynchronously):
  - state goes to CLEAR, clr_ptr goes to 0, busy goes to 1.
  - Array contents are not touched asynchronously.
- CLEAR state:
  - Each rising clk with rst low writes 0 to Register[clr_ptr], then increments clr_ptr.
  - When clr_ptr == NREGS-1 is written, next state is IDLE and busy falls.
  - Total: NREGS clocks after rst deasserts; busy low on the NREGS-th edge.
- IDLE state: remains there until rst is asserted again.
- Reset mid-clear: re-asserting rst restarts the sweep from clr_ptr = 0.
- RD1/RD2 during busy: read 0 regardless of address.
- RegWrite during busy: ignored; the sweep has priority and no write is queued.
- IDLE write: RegWrite=1 and Addr3 != 0 writes WD3 into Register[Addr3] at the rising edge.
- Write to address 0: silently dropped.
- IDLE read: RDn = Register[Addrn] combinationally.
- Address 0 read: always returns 0, independent of array contents.
- Read-during-write, same address, bypass disabled: RDn returns the old value until the edge and the new value after it.
- Both read ports may address the same register; both return identical data.
- Widths: no arithmetic is performed. Addresses are exactly ADDR_W bits, so there is no out-of-range case.
- Outputs at reset: busy=1, RD1=0, RD2=0.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- When defined:
  - In IDLE with RegWrite=1, Addr3 != 0 and Addr3 == Addrn, RDn = WD3 combinationally in the same cycle (write-to-read forwarding).
  - Removes the writeback-to-decode hazard.
  - Bypass is suppressed while busy and for address 0.
- When undefined: reads see array contents only; no forwarding mux is built.

Test Plan:
- Reset sweep:
  - Stimulus: assert rst for 3 cycles, release, and hold RegWrite=1, Addr3=5, WD3=32'hDEAD_BEEF for the whole sweep.
  - Required: busy=1 for exactly 32 edges and RD1=RD2=0 throughout.
  - Required: after busy falls, a read of Addr1=5 returns 0.
- Basic write/read:
  - Stimulus: in IDLE, write 32'h0000_1234 to register 7, then set Addr1=7, Addr2=7.
  - Required: RD1=RD2=32'h0000_1234 on the next cycle.
- x0 hardwiring:
  - Stimulus: write 32'hFFFF_FFFF to Addr3=0, then read Addr1=0.
  - Required: RD1=0.
- Same-cycle read/write of register 9:
  - Stimulus: register 9 holds 32'h1; write 32'h2 to it while Addr2=9.
  - Required without REG_FILE_BYPASS_EN: RD2=32'h1 before the edge, 32'h2 after.
  - Required with REG_FILE_BYPASS_EN: RD2=32'h2 in the same cycle.
- Mid-sweep reset:
  - Stimulus: release rst, wait 10 cycles, pulse rst for 1 cycle asynchronously (between edges).
  - Required: busy stays 1, and busy falls exactly 32 edges after the second release.
- Parameter variant DATA_W=64, NREGS=16:
  - Required: sweep lasts 16 cycles.
  - Required: writing 64'h0123_4567_89AB_CDEF to register 15 reads back intact.
